axi4lite_arbiter_2to1: RTL and testbench
========================================

Name: axi4lite_arbiter_2to1

Overview:
- Shares one AXI4-Lite subordinate port (our register-bank slave) between two AXI4-Lite manager ports, M0 and M1.
- Grants exactly one manager for one complete transaction (read or write) at a time, then re-arbitrates.
- Sits between the managers and the slave; all channel signals are muxed and demuxed in-block.

Parameters:
- AXI_ADDR_WIDTH, 32, address width on all ports.
- AXI_DATA_WIDTH, 32, data width on all ports.

Ports:
- A_CLK  in  1  single clock; all logic rises on posedge.
- A_RST  in  1  reset, synchronous, active-high.
- Mi_AW_VALID/Mi_AW_READY/Mi_AW_ADDR  in/out/in  1/1/AXI_ADDR_WIDTH  manager i (i=0,1) write address.
- Mi_W_VALID/Mi_W_READY/Mi_W_DATA  in/out/in  1/1/AXI_DATA_WIDTH  manager i write data.
- Mi_B_VALID/Mi_B_READY/Mi_B_RESP  out/in/out  1/1/2  manager i write response.
- Mi_AR_VALID/Mi_AR_READY/Mi_AR_ADDR  in/out/in  1/1/AXI_ADDR_WIDTH  manager i read address.
- Mi_R_VALID/Mi_R_READY/Mi_R_DATA/Mi_R_RESP  out/in/out/out  1/1/AXI_DATA_WIDTH/2  manager i read data.
- S_AW_*, S_W_*, S_B_*, S_AR_*, S_R_*  mirrored directions and widths  subordinate side.
- GNT  out  2  one-hot owner of the current transaction; 2'b00 when idle.

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP. Registered owner bit `own` and priority pointer `last`.
- Request: req_i = Mi_AR_VALID | Mi_AW_VALID | Mi_W_VALID.
- IDLE, one requester: grant it.
- IDLE, both requesting: grant the manager != last (round-robin).
- Transaction type on grant: AR_VALID of the winner → RD_ADDR; otherwise → WR_ADDR_DATA. Read wins if the owner asserts both.
- Latency: grant is registered. A request sampled at edge N connects the owner's channels from cycle N+1. Valid/ready/data paths are combinational pass-through once granted, adding no extra cycles.
- RD_ADDR: S_AR_* = owner AR. On S_AR handshake → RD_DATA.
- RD_DATA: S_R_* routed to owner R; S_R_READY = owner R_READY. On R handshake → IDLE, last <= own.
- WR_ADDR_DATA: AW and W pass independently, tracked by aw_done and w_done flags.
  - S_AW_VALID = owner AW_VALID & !aw_done.
  - S_W_VALID = owner W_VALID & !w_done.
  - Owner AW_READY/W_READY are gated the same way.
  - Either order, or simultaneous, is allowed. When both are done (including same-cycle) → WR_RESP, and the flags clear.
- WR_RESP: S_B_* routed to owner. On B handshake → IDLE, last <= own.
- RESP and DATA are passed unmodified; the arbiter never generates responses.
- Non-owner, and both managers while in IDLE:
  - all *_READY = 0;
  - B_VALID = R_VALID = 0;
  - R_DATA = 0, RESP = 0.
- S side in IDLE: all VALIDs 0, ADDR/DATA 0, S_B_READY = S_R_READY = 0.
- Back-to-back: at least one IDLE cycle between transactions. The max-throughput pattern is 1 transaction per (handshake cycles + 1).
- A non-owner request is held pending with no timeout; VALID may stay high indefinitely.
- Reset:
  - Any state → IDLE, GNT = 0, flags = 0, last = 1 (M0 wins the first contest).
  - All outputs 0 during and after reset until the next grant.
  - A transaction in flight is abandoned and no response is issued.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: M0 always wins simultaneous requests; `last` is unused. A transaction in progress is still never pre-empted.
- Undefined: round-robin as specified above.

Test Plan:
- Single read: M0 AR 0x04, slave R_DATA 0xDEADBEEF RESP 0 → M0 sees R_DATA 0xDEADBEEF, GNT=01 from cycle after AR_VALID, M1 all READY 0.
- Contention after reset: M0 and M1 AR in the same cycle → M0 served first, M1 second, GNT 01 → 00 → 10.
- Round-robin: both continuously issue reads, 4 transactions → order M0, M1, M0, M1. With ARB_FIXED_PRIO_EN → M0 ×4, M1 starved.
- Write skew: M1 W 0xA5A5A5A5 two cycles before AW 0x08 → one S_W handshake, one S_AW handshake, single B to M1, no duplicate W on the S side.
- Simultaneous AW/W plus B stall: M0 AW 0x0C and W in the same cycle, S_B_VALID held 3 cycles with M0_B_READY=0 → state stays WR_RESP, M1 AR request not granted until the B handshake.
- Reset mid-read: assert A_RST in RD_DATA → next cycle GNT=0, all VALID/READY 0. After release, a new M1 read completes normally.

Source files
------------

// File: rtl/axi4lite_arbiter_2to1.sv
// rtl/axi4lite_arbiter_2to1.sv - 2:1 AXI4-Lite manager arbiter onto one subordinate port
// Optional macro ARB_FIXED_PRIO_EN: M0 always wins simultaneous requests (default: round-robin).
module axi4lite_arbiter_2to1 #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                      A_CLK,
  input  logic                      A_RST,
  // manager 0
  input  logic                      M0_AW_VALID,
  output logic                      M0_AW_READY,
  input  logic [AXI_ADDR_WIDTH-1:0] M0_AW_ADDR,
  input  logic                      M0_W_VALID,
  output logic                      M0_W_READY,
  input  logic [AXI_DATA_WIDTH-1:0] M0_W_DATA,
  output logic                      M0_B_VALID,
  input  logic                      M0_B_READY,
  output logic [1:0]                M0_B_RESP,
  input  logic                      M0_AR_VALID,
  output logic                      M0_AR_READY,
  input  logic [AXI_ADDR_WIDTH-1:0] M0_AR_ADDR,
  output logic                      M0_R_VALID,
  input  logic                      M0_R_READY,
  output logic [AXI_DATA_WIDTH-1:0] M0_R_DATA,
  output logic [1:0]                M0_R_RESP,
  // manager 1
  input  logic                      M1_AW_VALID,
  output logic                      M1_AW_READY,
  input  logic [AXI_ADDR_WIDTH-1:0] M1_AW_ADDR,
  input  logic                      M1_W_VALID,
  output logic                      M1_W_READY,
  input  logic [AXI_DATA_WIDTH-1:0] M1_W_DATA,
  output logic                      M1_B_VALID,
  input  logic                      M1_B_READY,
  output logic [1:0]                M1_B_RESP,
  input  logic                      M1_AR_VALID,
  output logic                      M1_AR_READY,
  input  logic [AXI_ADDR_WIDTH-1:0] M1_AR_ADDR,
  output logic                      M1_R_VALID,
  input  logic                      M1_R_READY,
  output logic [AXI_DATA_WIDTH-1:0] M1_R_DATA,
  output logic [1:0]                M1_R_RESP,
  // subordinate
  output logic                      S_AW_VALID,
  input  logic                      S_AW_READY,
  output logic [AXI_ADDR_WIDTH-1:0] S_AW_ADDR,
  output logic                      S_W_VALID,
  input  logic                      S_W_READY,
  output logic [AXI_DATA_WIDTH-1:0] S_W_DATA,
  input  logic                      S_B_VALID,
  output logic                      S_B_READY,
  input  logic [1:0]                S_B_RESP,
  output logic                      S_AR_VALID,
  input  logic                      S_AR_READY,
  output logic [AXI_ADDR_WIDTH-1:0] S_AR_ADDR,
  input  logic                      S_R_VALID,
  output logic                      S_R_READY,
  input  logic [AXI_DATA_WIDTH-1:0] S_R_DATA,
  input  logic [1:0]                S_R_RESP,
  // current owner
  output logic [1:0]                GNT
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR_DATA,
    WR_RESP
  } state_t;

  state_t state, state_nxt;
  logic   own, own_nxt;
  logic   aw_done, aw_done_nxt;
  logic   w_done, w_done_nxt;
  logic   winner;
`ifndef ARB_FIXED_PRIO_EN
  logic   last, last_nxt;
`endif

  logic req0, req1;
  logic busy;

  // owner-side inputs, selected by the registered owner bit
  logic                      o_aw_valid, o_w_valid, o_b_ready, o_ar_valid, o_r_ready;
  logic [AXI_ADDR_WIDTH-1:0] o_aw_addr, o_ar_addr;
  logic [AXI_DATA_WIDTH-1:0] o_w_data;

  // owner-side outputs before being steered to M0 or M1
  logic                      g_aw_ready, g_w_ready, g_b_valid, g_ar_ready, g_r_valid;
  logic [1:0]                g_b_resp, g_r_resp;
  logic [AXI_DATA_WIDTH-1:0] g_r_data;

  logic s_aw_hs, s_w_hs, s_ar_hs, s_r_hs, s_b_hs;

  assign req0 = M0_AR_VALID | M0_AW_VALID | M0_W_VALID;
  assign req1 = M1_AR_VALID | M1_AW_VALID | M1_W_VALID;

  // Reset is gated in combinationally so nothing is presented or accepted while it is high.
  assign busy = (state != IDLE) && !A_RST;

  assign o_aw_valid = own ? M1_AW_VALID : M0_AW_VALID;
  assign o_aw_addr  = own ? M1_AW_ADDR  : M0_AW_ADDR;
  assign o_w_valid  = own ? M1_W_VALID  : M0_W_VALID;
  assign o_w_data   = own ? M1_W_DATA   : M0_W_DATA;
  assign o_b_ready  = own ? M1_B_READY  : M0_B_READY;
  assign o_ar_valid = own ? M1_AR_VALID : M0_AR_VALID;
  assign o_ar_addr  = own ? M1_AR_ADDR  : M0_AR_ADDR;
  assign o_r_ready  = own ? M1_R_READY  : M0_R_READY;

  assign s_aw_hs = S_AW_VALID & S_AW_READY;
  assign s_w_hs  = S_W_VALID  & S_W_READY;
  assign s_ar_hs = S_AR_VALID & S_AR_READY;
  assign s_r_hs  = S_R_VALID  & S_R_READY;
  assign s_b_hs  = S_B_VALID  & S_B_READY;

  assign GNT = busy ? (own ? 2'b10 : 2'b01) : 2'b00;

  // Only the channel pair belonging to the current state is connected; everything else idles at 0.
  always_comb begin
    S_AW_VALID = 1'b0;
    S_AW_ADDR  = '0;
    S_W_VALID  = 1'b0;
    S_W_DATA   = '0;
    S_B_READY  = 1'b0;
    S_AR_VALID = 1'b0;
    S_AR_ADDR  = '0;
    S_R_READY  = 1'b0;
    g_aw_ready = 1'b0;
    g_w_ready  = 1'b0;
    g_b_valid  = 1'b0;
    g_b_resp   = 2'b00;
    g_ar_ready = 1'b0;
    g_r_valid  = 1'b0;
    g_r_data   = '0;
    g_r_resp   = 2'b00;
    if (busy) begin
      case (state)
        RD_ADDR: begin
          S_AR_VALID = o_ar_valid;
          S_AR_ADDR  = o_ar_addr;
          g_ar_ready = S_AR_READY;
        end
        RD_DATA: begin
          S_R_READY = o_r_ready;
          g_r_valid = S_R_VALID;
          g_r_data  = S_R_DATA;
          g_r_resp  = S_R_RESP;
        end
        WR_ADDR_DATA: begin
          // a channel that already handshook is masked so it cannot repeat
          S_AW_VALID = o_aw_valid & !aw_done;
          S_AW_ADDR  = o_aw_addr;
          S_W_VALID  = o_w_valid & !w_done;
          S_W_DATA   = o_w_data;
          g_aw_ready = S_AW_READY & !aw_done;
          g_w_ready  = S_W_READY & !w_done;
        end
        WR_RESP: begin
          S_B_READY = o_b_ready;
          g_b_valid = S_B_VALID;
          g_b_resp  = S_B_RESP;
        end
        default: begin
          S_AW_VALID = 1'b0;
        end
      endcase
    end
  end

  // Steer the owner-side outputs to the granted manager; the other one sees all zeros.
  always_comb begin
    M0_AW_READY = g_aw_ready & !own;
    M0_W_READY  = g_w_ready  & !own;
    M0_B_VALID  = g_b_valid  & !own;
    M0_B_RESP   = own ? 2'b00 : g_b_resp;
    M0_AR_READY = g_ar_ready & !own;
    M0_R_VALID  = g_r_valid  & !own;
    M0_R_DATA   = own ? '0 : g_r_data;
    M0_R_RESP   = own ? 2'b00 : g_r_resp;
    M1_AW_READY = g_aw_ready & own;
    M1_W_READY  = g_w_ready  & own;
    M1_B_VALID  = g_b_valid  & own;
    M1_B_RESP   = own ? g_b_resp : 2'b00;
    M1_AR_READY = g_ar_ready & own;
    M1_R_VALID  = g_r_valid  & own;
    M1_R_DATA   = own ? g_r_data : '0;
    M1_R_RESP   = own ? g_r_resp : 2'b00;
  end

  // Arbitration and transaction sequencing: one whole read or write per grant.
  always_comb begin
    state_nxt   = state;
    own_nxt     = own;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    winner      = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    last_nxt    = last;
`endif
    case (state)
      IDLE: begin
        if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
          winner = 1'b0;
`else
          winner = ~last;
`endif
        end else begin
          winner = req1;
        end
        if (req0 || req1) begin
          own_nxt   = winner;
          state_nxt = (winner ? M1_AR_VALID : M0_AR_VALID) ? RD_ADDR : WR_ADDR_DATA;
        end
      end
      RD_ADDR: begin
        if (s_ar_hs) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        if (s_r_hs) begin
          state_nxt = IDLE;
`ifndef ARB_FIXED_PRIO_EN
          last_nxt  = own;
`endif
        end
      end
      WR_ADDR_DATA: begin
        if ((aw_done || s_aw_hs) && (w_done || s_w_hs)) begin
          state_nxt   = WR_RESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end else begin
          aw_done_nxt = aw_done | s_aw_hs;
          w_done_nxt  = w_done | s_w_hs;
        end
      end
      WR_RESP: begin
        if (s_b_hs) begin
          state_nxt = IDLE;
`ifndef ARB_FIXED_PRIO_EN
          last_nxt  = own;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, owner, write-progress flags and priority pointer; reset abandons any transaction.
  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      state   <= IDLE;
      own     <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last    <= 1'b1;
`endif
    end else begin
      state   <= state_nxt;
      own     <= own_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
`ifndef ARB_FIXED_PRIO_EN
      last    <= last_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_axi4lite_arbiter_2to1.sv
// tb/tb_axi4lite_arbiter_2to1.sv - directed bench for axi4lite_arbiter_2to1
module tb_axi4lite_arbiter_2to1;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          A_CLK = 1'b0;
  logic          A_RST;
  logic          M0_AW_VALID, M0_AW_READY, M0_W_VALID, M0_W_READY, M0_B_VALID, M0_B_READY;
  logic          M0_AR_VALID, M0_AR_READY, M0_R_VALID, M0_R_READY;
  logic [AW-1:0] M0_AW_ADDR, M0_AR_ADDR;
  logic [DW-1:0] M0_W_DATA, M0_R_DATA;
  logic [1:0]    M0_B_RESP, M0_R_RESP;
  logic          M1_AW_VALID, M1_AW_READY, M1_W_VALID, M1_W_READY, M1_B_VALID, M1_B_READY;
  logic          M1_AR_VALID, M1_AR_READY, M1_R_VALID, M1_R_READY;
  logic [AW-1:0] M1_AW_ADDR, M1_AR_ADDR;
  logic [DW-1:0] M1_W_DATA, M1_R_DATA;
  logic [1:0]    M1_B_RESP, M1_R_RESP;
  logic          S_AW_VALID, S_AW_READY, S_W_VALID, S_W_READY, S_B_VALID, S_B_READY;
  logic          S_AR_VALID, S_AR_READY, S_R_VALID, S_R_READY;
  logic [AW-1:0] S_AW_ADDR, S_AR_ADDR;
  logic [DW-1:0] S_W_DATA, S_R_DATA;
  logic [1:0]    S_B_RESP, S_R_RESP;
  logic [1:0]    GNT;

  always #5 A_CLK = ~A_CLK;

  axi4lite_arbiter_2to1 #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .A_CLK(A_CLK), .A_RST(A_RST),
    .M0_AW_VALID(M0_AW_VALID), .M0_AW_READY(M0_AW_READY), .M0_AW_ADDR(M0_AW_ADDR),
    .M0_W_VALID(M0_W_VALID), .M0_W_READY(M0_W_READY), .M0_W_DATA(M0_W_DATA),
    .M0_B_VALID(M0_B_VALID), .M0_B_READY(M0_B_READY), .M0_B_RESP(M0_B_RESP),
    .M0_AR_VALID(M0_AR_VALID), .M0_AR_READY(M0_AR_READY), .M0_AR_ADDR(M0_AR_ADDR),
    .M0_R_VALID(M0_R_VALID), .M0_R_READY(M0_R_READY), .M0_R_DATA(M0_R_DATA), .M0_R_RESP(M0_R_RESP),
    .M1_AW_VALID(M1_AW_VALID), .M1_AW_READY(M1_AW_READY), .M1_AW_ADDR(M1_AW_ADDR),
    .M1_W_VALID(M1_W_VALID), .M1_W_READY(M1_W_READY), .M1_W_DATA(M1_W_DATA),
    .M1_B_VALID(M1_B_VALID), .M1_B_READY(M1_B_READY), .M1_B_RESP(M1_B_RESP),
    .M1_AR_VALID(M1_AR_VALID), .M1_AR_READY(M1_AR_READY), .M1_AR_ADDR(M1_AR_ADDR),
    .M1_R_VALID(M1_R_VALID), .M1_R_READY(M1_R_READY), .M1_R_DATA(M1_R_DATA), .M1_R_RESP(M1_R_RESP),
    .S_AW_VALID(S_AW_VALID), .S_AW_READY(S_AW_READY), .S_AW_ADDR(S_AW_ADDR),
    .S_W_VALID(S_W_VALID), .S_W_READY(S_W_READY), .S_W_DATA(S_W_DATA),
    .S_B_VALID(S_B_VALID), .S_B_READY(S_B_READY), .S_B_RESP(S_B_RESP),
    .S_AR_VALID(S_AR_VALID), .S_AR_READY(S_AR_READY), .S_AR_ADDR(S_AR_ADDR),
    .S_R_VALID(S_R_VALID), .S_R_READY(S_R_READY), .S_R_DATA(S_R_DATA), .S_R_RESP(S_R_RESP),
    .GNT(GNT)
  );

  typedef struct {
    logic        m0_ar, m1_ar, m0_rr, m1_rr, s_arr, s_rv;
    logic [31:0] s_rdata;
    logic [1:0]  gnt;
    logic        s_arv;
    logic [31:0] s_araddr;
    logic        m0_arr, m1_arr, m0_rv, m1_rv;
    logic [31:0] m0_rd, m1_rd;
  } vec_t;

  vec_t        tbl [12];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          c_sw, c_saw, c_m0b, c_m1b;
  logic [31:0] sw_data, saw_addr;
  logic [1:0]  order [4];
  int          n_ord;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // wait to the falling edge and tally subordinate/manager handshakes seen there
  task automatic half();
    @(negedge A_CLK);
    if (S_W_VALID && S_W_READY) begin c_sw++; sw_data = S_W_DATA; end
    if (S_AW_VALID && S_AW_READY) begin c_saw++; saw_addr = S_AW_ADDR; end
    if (M0_B_VALID && M0_B_READY) c_m0b++;
    if (M1_B_VALID && M1_B_READY) c_m1b++;
  endtask

  task automatic adv();
    @(posedge A_CLK);
    #1;
  endtask

  task automatic clr_counts();
    c_sw = 0; c_saw = 0; c_m0b = 0; c_m1b = 0; sw_data = '0; saw_addr = '0;
  endtask

  task automatic zero_inputs();
    M0_AW_VALID = 0; M0_W_VALID = 0; M0_B_READY = 0; M0_AR_VALID = 0; M0_R_READY = 0;
    M1_AW_VALID = 0; M1_W_VALID = 0; M1_B_READY = 0; M1_AR_VALID = 0; M1_R_READY = 0;
    S_AW_READY = 0; S_W_READY = 0; S_B_VALID = 0; S_B_RESP = 2'b00;
    S_AR_READY = 0; S_R_VALID = 0; S_R_DATA = '0; S_R_RESP = 2'b00;
    M0_AW_ADDR = 32'h0000_000C; M0_AR_ADDR = 32'h0000_0004; M0_W_DATA = 32'h1234_5678;
    M1_AW_ADDR = 32'h0000_0008; M1_AR_ADDR = 32'h0000_0010; M1_W_DATA = 32'hA5A5_A5A5;
  endtask

  task automatic do_reset();
    A_RST = 1'b1;
    zero_inputs();
    adv();
    adv();
    A_RST = 1'b0;
  endtask

  initial begin
    //            m0ar m1ar m0rr m1rr sarr srv  s_rdata       gnt    sarv saraddr     m0arr m1arr m0rv m1rv m0_rd         m1_rd
    tbl[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        2'b00, 1'b0,32'h0,  1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};
    tbl[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,32'h0,        2'b01, 1'b1,32'h4,  1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0};
    tbl[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,32'h11111111, 2'b01, 1'b0,32'h0,  1'b0,1'b0,1'b1,1'b0,32'h11111111, 32'h0};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        2'b00, 1'b0,32'h0,  1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,32'h0,        2'b10, 1'b1,32'h10, 1'b0,1'b1,1'b0,1'b0,32'h0,        32'h0};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,32'h22222222, 2'b10, 1'b0,32'h0,  1'b0,1'b0,1'b0,1'b1,32'h0,        32'h22222222};
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        2'b00, 1'b0,32'h0,  1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        2'b00, 1'b0,32'h0,  1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,        2'b01, 1'b1,32'h4,  1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0};
    tbl[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        2'b01, 1'b0,32'h0,  1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};
    tbl[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,32'hDEADBEEF, 2'b01, 1'b0,32'h0,  1'b0,1'b0,1'b1,1'b0,32'hDEADBEEF, 32'h0};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        2'b00, 1'b0,32'h0,  1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};

    zero_inputs();
    clr_counts();
    A_RST = 1'b1;
    adv();
    // outputs must stay quiet while reset is held, even with a request present
    M0_AR_VALID = 1'b1;
    half();
    check("rst_hold_gnt", {30'd0, GNT}, 32'd0);
    check("rst_hold_m0_arready", {31'd0, M0_AR_READY}, 32'd0);
    adv();
    do_reset();

    // reset state
    half();
    check("rst_gnt", {30'd0, GNT}, 32'd0);
    check("rst_s_valids", {29'd0, S_AR_VALID, S_AW_VALID, S_W_VALID}, 32'd0);
    check("rst_s_readys", {30'd0, S_B_READY, S_R_READY}, 32'd0);
    check("rst_m_readys", {28'd0, M0_AR_READY, M1_AR_READY, M0_W_READY, M1_AW_READY}, 32'd0);
    adv();

    // contention after reset, then single read, table-driven
    for (int i = 0; i < 12; i++) begin
      M0_AR_VALID = tbl[i].m0_ar;
      M1_AR_VALID = tbl[i].m1_ar;
      M0_R_READY  = tbl[i].m0_rr;
      M1_R_READY  = tbl[i].m1_rr;
      S_AR_READY  = tbl[i].s_arr;
      S_R_VALID   = tbl[i].s_rv;
      S_R_DATA    = tbl[i].s_rdata;
      half();
      check($sformatf("v%0d_gnt", i), {30'd0, GNT}, {30'd0, tbl[i].gnt});
      check($sformatf("v%0d_s_arvalid", i), {31'd0, S_AR_VALID}, {31'd0, tbl[i].s_arv});
      check($sformatf("v%0d_s_araddr", i), S_AR_ADDR, tbl[i].s_araddr);
      check($sformatf("v%0d_m0_arready", i), {31'd0, M0_AR_READY}, {31'd0, tbl[i].m0_arr});
      check($sformatf("v%0d_m1_arready", i), {31'd0, M1_AR_READY}, {31'd0, tbl[i].m1_arr});
      check($sformatf("v%0d_m0_rvalid", i), {31'd0, M0_R_VALID}, {31'd0, tbl[i].m0_rv});
      check($sformatf("v%0d_m1_rvalid", i), {31'd0, M1_R_VALID}, {31'd0, tbl[i].m1_rv});
      check($sformatf("v%0d_m0_rdata", i), M0_R_DATA, tbl[i].m0_rd);
      check($sformatf("v%0d_m1_rdata", i), M1_R_DATA, tbl[i].m1_rd);
      adv();
    end

    // round-robin with both managers reading continuously
    do_reset();
    M0_AR_VALID = 1; M1_AR_VALID = 1; M0_R_READY = 1; M1_R_READY = 1;
    S_AR_READY = 1; S_R_VALID = 1; S_R_DATA = 32'h0000_00AA;
    n_ord = 0;
    for (int cyc = 0; cyc < 40 && n_ord < 4; cyc++) begin
      half();
      if (S_R_VALID && S_R_READY) begin
        order[n_ord] = GNT;
        n_ord++;
      end
      adv();
    end
    check("rr_count", n_ord, 4);
    for (int k = 0; k < 4 && k < n_ord; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      check($sformatf("rr_order%0d", k), {30'd0, order[k]}, 32'd1);
`else
      check($sformatf("rr_order%0d", k), {30'd0, order[k]}, (k % 2 == 0) ? 32'd1 : 32'd2);
`endif
    end
    zero_inputs();
    adv();
    adv();

    // write skew: M1 W two cycles ahead of AW
    clr_counts();
    S_W_READY = 1; S_AW_READY = 1;
    M1_W_VALID = 1;
    half();
    check("ws_idle_gnt", {30'd0, GNT}, 32'd0);
    adv();
    half();
    check("ws_gnt", {30'd0, GNT}, 32'd2);
    check("ws_m1_wready", {31'd0, M1_W_READY}, 32'd1);
    adv();
    M1_AW_VALID = 1;
    half();
    check("ws_no_dup_w", {31'd0, S_W_VALID}, 32'd0);
    check("ws_s_awvalid", {31'd0, S_AW_VALID}, 32'd1);
    adv();
    M1_AW_VALID = 0; M1_W_VALID = 0; S_B_VALID = 1; S_B_RESP = 2'b10; M1_B_READY = 1;
    half();
    check("ws_m1_bvalid", {31'd0, M1_B_VALID}, 32'd1);
    check("ws_m1_bresp", {30'd0, M1_B_RESP}, 32'd2);
    check("ws_m0_bvalid", {31'd0, M0_B_VALID}, 32'd0);
    adv();
    S_B_VALID = 0; S_B_RESP = 2'b00; M1_B_READY = 0;
    half();
    check("ws_end_gnt", {30'd0, GNT}, 32'd0);
    adv();
    check("ws_sw_count", c_sw, 1);
    check("ws_saw_count", c_saw, 1);
    check("ws_m1_b_count", c_m1b, 1);
    check("ws_m0_b_count", c_m0b, 0);
    check("ws_w_data", sw_data, 32'hA5A5_A5A5);
    check("ws_aw_addr", saw_addr, 32'h0000_0008);

    // simultaneous AW/W from M0 with a stalled B while M1 waits to read
    clr_counts();
    M0_AW_VALID = 1; M0_W_VALID = 1; M1_AR_VALID = 1;
    half();
    adv();
    half();
    check("bs_gnt", {30'd0, GNT}, 32'd1);
    check("bs_s_aw_w", {30'd0, S_AW_VALID, S_W_VALID}, 32'd3);
    adv();
    M0_AW_VALID = 0; M0_W_VALID = 0; S_B_VALID = 1; M0_B_READY = 0;
    for (int k = 0; k < 3; k++) begin
      half();
      check($sformatf("bs_stall%0d_gnt", k), {30'd0, GNT}, 32'd1);
      check($sformatf("bs_stall%0d_m0_bvalid", k), {31'd0, M0_B_VALID}, 32'd1);
      check($sformatf("bs_stall%0d_m1_arready", k), {30'd0, M1_AR_READY, S_AR_VALID}, 32'd0);
      adv();
    end
    M0_B_READY = 1;
    half();
    check("bs_release_gnt", {30'd0, GNT}, 32'd1);
    adv();
    M0_B_READY = 0; S_B_VALID = 0;
    half();
    check("bs_idle_gnt", {30'd0, GNT}, 32'd0);
    adv();
    S_AR_READY = 1;
    half();
    check("bs_m1_gnt", {30'd0, GNT}, 32'd2);
    check("bs_m1_araddr", S_AR_ADDR, 32'h0000_0010);
    adv();
    check("bs_counts", {c_saw[7:0], c_sw[7:0], c_m0b[7:0], c_m1b[7:0]}, 32'h0101_0100);

    // reset while M1 is in its read data phase
    M1_AR_VALID = 0; S_AR_READY = 0;
    half();
    check("mr_gnt_before", {30'd0, GNT}, 32'd2);
    A_RST = 1'b1;
    adv();
    A_RST = 1'b0;
    S_R_VALID = 1; S_R_DATA = 32'hCAFE_F00D; M1_R_READY = 1;
    half();
    check("mr_gnt_after", {30'd0, GNT}, 32'd0);
    check("mr_quiet", {27'd0, M1_R_VALID, M0_R_VALID, S_R_READY, S_AR_VALID, M1_AR_READY}, 32'd0);
    adv();
    S_R_VALID = 0; M1_AR_VALID = 1;
    half();
    adv();
    S_AR_READY = 1;
    half();
    check("mr_m1_arready", {31'd0, M1_AR_READY}, 32'd1);
    adv();
    M1_AR_VALID = 0; S_AR_READY = 0; S_R_VALID = 1; S_R_DATA = 32'h0BAD_F00D; S_R_RESP = 2'b01;
    half();
    check("mr_m1_rvalid", {31'd0, M1_R_VALID}, 32'd1);
    check("mr_m1_rdata", M1_R_DATA, 32'h0BAD_F00D);
    check("mr_m1_rresp", {30'd0, M1_R_RESP}, 32'd1);
    adv();
    zero_inputs();
    half();
    check("mr_end_gnt", {30'd0, GNT}, 32'd0);
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
